cmd_arb: RTL
============

# cmd_arb

Two-source command arbiter in front of `cmd_cntrl`. It shares that block's single `cmd`/`cmd_rdy`/`clr_cmd_rdy` interface between source A (wireless remote UART) and source B (on-board console UART). It picks one pending command, presents it, and clears the source's ready flag. It holds the command until `cmd_cntrl` acknowledges it or a timeout expires. Fairness is round-robin, with optional stop-command preemption.

## Interface
- `TIMEOUT_CYC`, 1024: cycles a presented command may wait for `clr_cmd_rdy` before it is dropped; ≥ 2; counter width is `$clog2(TIMEOUT_CYC)`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_cmd`  in  8  source A command; bits [7:6] opcode (`2'b01` go, `2'b00` stop), bits [5:0] destination ID.
- `a_rdy`  in  1  source A has a command pending.
- `a_clr`  out  1  one-cycle pulse that clears source A's ready flag.
- `b_cmd`  in  8  source B command; same format as `a_cmd`.
- `b_rdy`  in  1  source B has a command pending.
- `b_clr`  out  1  one-cycle pulse that clears source B's ready flag.
- `cmd`  out  8  command presented to `cmd_cntrl` (registered).
- `cmd_rdy`  out  1  `cmd` is valid.
- `clr_cmd_rdy`  in  1  acknowledge from `cmd_cntrl`.
- `grant_b`  out  1  owner of the current or last command: 0 = A, 1 = B.
- `drop`  out  1  one-cycle pulse when a presented command is discarded (timeout or preemption).
- `busy`  out  1  high in PRESENT or GAP.

## Operation
- Reset values:
  - `cmd`=8'h00; `grant_b`=0.
  - `cmd_rdy`, `a_clr`, `b_clr`, `drop`, `busy` = 0.
  - State IDLE; round-robin pointer "last served = B", so A wins the first tie.
- States: IDLE, PRESENT, GAP.
- IDLE:
  - Only one of `a_rdy`/`b_rdy` set: that source is selected.
  - Both set: the source not last served is selected.
  - On selection: latch its `cmd` into `cmd`; set `cmd_rdy`, `grant_b`, and that source's clr pulse; update the pointer; clear the timer; go to PRESENT.
- PRESENT:
  - `cmd` and `cmd_rdy` are held stable. The only exception is preemption (see Configuration).
  - Timer increments each cycle.
  - `clr_cmd_rdy`=1: `cmd_rdy`←0, go to GAP.
  - Timer reaches `TIMEOUT_CYC-1` without `clr_cmd_rdy`: `cmd_rdy`←0, pulse `drop`, go to GAP.
  - Timeout and `clr_cmd_rdy` in the same cycle: the acknowledge wins and `drop` stays 0.
- GAP: one cycle, then IDLE. This guarantees a source's stale `rdy` is never accepted twice.
- `clr_cmd_rdy` in IDLE or GAP is ignored.
- `a_rdy`/`b_rdy` are not sampled in PRESENT or GAP. The exception is preemption.
- Asserting `rst` mid-operation returns all outputs to their reset values immediately. An in-flight command is lost; `drop` is not pulsed.

## Timing
- `rdy` sampled high in IDLE at cycle N → `cmd_rdy`, `cmd`, and the clr pulse are valid in cycle N+1. The clr pulse lasts exactly one cycle.
- `clr_cmd_rdy` high at cycle M → `cmd_rdy` low at M+1 (GAP) → IDLE at M+2 → next `cmd_rdy` at M+3 at the earliest.
- Minimum command period is 3 cycles.
- Timeout: `cmd_rdy` stays high for exactly `TIMEOUT_CYC` cycles, then `drop` pulses in the first cycle with `cmd_rdy` low.

## Configuration
- Macro: `CMD_ARB_STOP_PREEMPT_EN`.
- Defined:
  - In IDLE, a stop (opcode `2'b00`) from either source beats a go, regardless of the pointer. If both sources present a stop, A wins.
  - In PRESENT with a go presented, if the other source raises `rdy` with a stop, then on the next edge:
    - `cmd` is replaced by the stop and `cmd_rdy` stays high;
    - the stop source's clr pulses, `drop` pulses, and `grant_b` updates;
    - the pointer updates and the timer restarts.
  - If `clr_cmd_rdy` arrives in that same cycle, the go is acknowledged instead and the stop waits in IDLE.
- Undefined: pure round-robin; no replacement in PRESENT.

## Test plan
- Reset, then `a_rdy`=1 with `a_cmd`=8'h76 → cycle+1: `cmd`=8'h76, `cmd_rdy`=1, `a_clr` pulses once, `grant_b`=0. Then `clr_cmd_rdy` pulse → `cmd_rdy`=0 next cycle.
- `a_rdy` and `b_rdy` held high, with `clr_cmd_rdy` issued 2 cycles after each `cmd_rdy` → grants alternate A, B, A, B. Consecutive `cmd_rdy` rises are at least 3 cycles apart.
- `TIMEOUT_CYC`=8, `b_rdy` with `b_cmd`=8'h64, no acknowledge → `cmd_rdy` high exactly 8 cycles; `drop` pulses once; IDLE follows after GAP.
- Timeout cycle coincides with `clr_cmd_rdy` → `drop` stays 0.
- `CMD_ARB_STOP_PREEMPT_EN` defined: A presents go 8'h76 and B raises stop 8'h24 during PRESENT → `cmd`=8'h24 next cycle; `b_clr` and `drop` pulse; `grant_b`=1. Undefined: `cmd` stays 8'h76 until acknowledged, then B is served.
- `rst` asserted while in PRESENT → `cmd_rdy`=0, `cmd`=8'h00, and the pointer is reset, so A wins the next tie.

Source files
------------

// File: rtl/cmd_arb.sv
// Two-source command arbiter sharing one cmd/cmd_rdy/clr_cmd_rdy channel into cmd_cntrl.
// Optional stop-command preemption is enabled by defining CMD_ARB_STOP_PREEMPT_EN.
module cmd_arb #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_cmd,
  input  logic       a_rdy,
  output logic       a_clr,
  input  logic [7:0] b_cmd,
  input  logic       b_rdy,
  output logic       b_clr,
  output logic [7:0] cmd,
  output logic       cmd_rdy,
  input  logic       clr_cmd_rdy,
  output logic       grant_b,
  output logic       drop,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } state_t;

  state_t        state;
  logic          last_b;
  logic [TW-1:0] timer;
  logic          any_rdy;
  logic          pick_b;

`ifdef CMD_ARB_STOP_PREEMPT_EN
  localparam logic [1:0] OP_GO   = 2'b01;
  localparam logic [1:0] OP_STOP = 2'b00;

  logic       a_stop;
  logic       b_stop;
  logic       other_rdy;
  logic [7:0] other_cmd;
  logic       preempt;
`endif

  // Source selection in IDLE: round-robin on a tie, stops first when preemption is built in.
  always_comb begin
    any_rdy = a_rdy | b_rdy;
    pick_b  = 1'b0;
    if (a_rdy && b_rdy) begin
      pick_b = ~last_b;
    end else begin
      pick_b = b_rdy;
    end
`ifdef CMD_ARB_STOP_PREEMPT_EN
    a_stop = a_rdy && (a_cmd[7:6] == OP_STOP);
    b_stop = b_rdy && (b_cmd[7:6] == OP_STOP);
    if (a_stop) begin
      pick_b = 1'b0;
    end else if (b_stop) begin
      pick_b = 1'b1;
    end
    other_rdy = grant_b ? a_rdy : b_rdy;
    other_cmd = grant_b ? a_cmd : b_cmd;
    preempt   = (state == PRESENT) && (cmd[7:6] == OP_GO) && other_rdy &&
                (other_cmd[7:6] == OP_STOP) && !clr_cmd_rdy;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      timer   <= '0;
      cmd     <= 8'h00;
      cmd_rdy <= 1'b0;
      grant_b <= 1'b0;
      a_clr   <= 1'b0;
      b_clr   <= 1'b0;
      drop    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      a_clr <= 1'b0;
      b_clr <= 1'b0;
      drop  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_rdy) begin
            cmd     <= pick_b ? b_cmd : a_cmd;
            cmd_rdy <= 1'b1;
            grant_b <= pick_b;
            a_clr   <= ~pick_b;
            b_clr   <= pick_b;
            last_b  <= pick_b;
            timer   <= '0;
            busy    <= 1'b1;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          // Acknowledge outranks both preemption and timeout.
          if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
            state   <= GAP;
          end
`ifdef CMD_ARB_STOP_PREEMPT_EN
          else if (preempt) begin
            cmd     <= other_cmd;
            grant_b <= ~grant_b;
            a_clr   <= grant_b;
            b_clr   <= ~grant_b;
            last_b  <= ~grant_b;
            drop    <= 1'b1;
            timer   <= '0;
          end
`endif
          else if (timer == TIMER_LAST) begin
            cmd_rdy <= 1'b0;
            drop    <= 1'b1;
            state   <= GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
